fetch_ctrl: RTL and testbench

Sequencing and arbitration controller for the instruction memory (`if_mem`) and the program counter. It owns the PC, the run/halt/error state of the front end, and the single memory port. That port is shared between instruction fetch and an external program loader that writes the image before or between runs. It sits in front of `if_mem` and drives the IF/ID pipeline register inputs.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/pc_next.sv | 42 ++++
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_state_e : front-end FSM state encoding (exported on state_p1)
//   PC_W          : program counter width
//   PC_RESET_DEF  : default PC loaded on reset
//   PC_INC_DEF    : default PC increment per fetched instruction (bytes)
package fetch_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] PC_RESET_DEF = 16'h0000;
  localparam int PC_INC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HALT = 3'd3,
    ST_ERR  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC selection for the fetch front end.
//   i_pc             : current PC
//   i_hold           : freeze PC (not fetching, halting or memory error)
//   i_redirect_valid : take i_redirect_pc
//   i_redirect_pc    : branch/jump target
//   i_stall          : hold PC this cycle
//   o_next_pc        : PC for the next cycle
//   o_misalign       : redirect target is odd; PC is left unchanged
module pc_next
  import fetch_pkg::*;
#(
  parameter int PC_INC = PC_INC_DEF
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_hold,
  input  logic            i_redirect_valid,
  input  logic [PC_W-1:0] i_redirect_pc,
  input  logic            i_stall,
  output logic [PC_W-1:0] o_next_pc,
  output logic            o_misalign
);

  localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

  // Redirect outranks stall; the increment wraps silently at 2^16.
  always_comb begin
    o_next_pc  = i_pc;
    o_misalign = 1'b0;
    if (!i_hold) begin
      if (i_redirect_valid) begin
        if (i_redirect_pc[0]) begin
          o_misalign = 1'b1;
        end else begin
          o_next_pc = i_redirect_pc;
        end
      end else if (!i_stall) begin
        o_next_pc = i_pc + INC;
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and arbiter of the single instruction-memory port,
// shared between instruction fetch (RUN) and the program loader (LOAD).
//   clk, rst                     : clock, synchronous active-high reset
//   start, halt                  : run control
//   stall_p1                     : hold PC, suppress instruction valid
//   redirect_valid, redirect_pc  : branch/jump target load
//   ld_req, ld_addr, ld_data     : loader write request; ld_ack = accepted
//   mem_addr/enable/wr/data_in   : to if_mem; mem_err from if_mem
//   pc_p1, inst_valid_p1         : PC presented this cycle and its validity
//   err_p1                       : sticky front-end error
//   state_p1                     : FSM state (fetch_state_e encoding)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEF,
  parameter int              PC_INC   = PC_INC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt,
  input  logic            stall_p1,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            ld_req,
  input  logic [PC_W-1:0] ld_addr,
  input  logic [PC_W-1:0] ld_data,
  output logic            ld_ack,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_enable,
  output logic            mem_wr,
  output logic [PC_W-1:0] mem_data_in,
  input  logic            mem_err,
  output logic [PC_W-1:0] pc_p1,
  output logic            inst_valid_p1,
  output logic            err_p1,
  output logic [2:0]      state_p1
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic            r_err;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_misalign;
  logic            w_pc_hold;

  // Memory error and halt outrank redirect/stall, so they freeze the PC too.
  assign w_pc_hold = (r_state != ST_RUN) | mem_err | halt;

  pc_next #(
    .PC_INC(PC_INC)
  ) u_pc_next (
    .i_pc             (r_pc),
    .i_hold           (w_pc_hold),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_stall          (stall_p1),
    .o_next_pc        (w_pc_nxt),
    .o_misalign       (w_misalign)
  );

  always_comb begin
    w_state_nxt   = r_state;
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_data_in   = '0;
    ld_ack        = 1'b0;
    inst_valid_p1 = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        // Entering LOAD costs one unacked cycle; the loader holds its request.
        if (ld_req) begin
          w_state_nxt = ST_LOAD;
        end else if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (ld_req) begin
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = ld_addr;
          mem_data_in = ld_data;
          ld_ack      = 1'b1;
        end
        if (mem_err) begin
          w_state_nxt = ST_ERR;
        end else if (!ld_req) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        mem_enable    = 1'b1;
        mem_addr      = r_pc;
        inst_valid_p1 = !(stall_p1 | redirect_valid | halt | mem_err);
        if (mem_err) begin
          w_state_nxt = ST_ERR;
        end else if (halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_misalign) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
      default: begin
        w_state_nxt = ST_ERR;
      end
    endcase
  end

  // ---- stage boundary: state, PC and error flag registered here ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= PC_RESET;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_err   <= r_err | (w_state_nxt == ST_ERR);
    end
  end

  assign pc_p1    = r_pc;
  assign err_p1   = r_err;
  assign state_p1 = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl. The driver applies inputs on
// the falling edge and pushes the reference model's expected cycle record (and
// expected fetched words) into queues; a monitor samples the DUT shortly after
// and pops/compares. A behavioural if_mem stand-in sits on the memory port.
module tb_fetch_ctrl;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_RUN  = 2;
  localparam int S_HALT = 3;
  localparam int S_ERR  = 4;

  logic        clk = 1'b0;
  logic        rst, start, halt, stall_p1, redirect_valid, ld_req, mem_err;
  logic [15:0] redirect_pc, ld_addr, ld_data;
  logic        ld_ack, mem_enable, mem_wr, inst_valid_p1, err_p1;
  logic [15:0] mem_addr, mem_data_in, pc_p1;
  logic [2:0]  state_p1;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .PC_RESET(16'h0000),
    .PC_INC  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .stall_p1       (stall_p1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ld_req         (ld_req),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_ack         (ld_ack),
    .mem_addr       (mem_addr),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_data_in    (mem_data_in),
    .mem_err        (mem_err),
    .pc_p1          (pc_p1),
    .inst_valid_p1  (inst_valid_p1),
    .err_p1         (err_p1),
    .state_p1       (state_p1)
  );

  // if_mem stand-in: word array, combinational read, write on clock edge
  logic [15:0] imem [0:32767];
  logic [15:0] mem_rdata;
  always @(posedge clk) if (mem_enable && mem_wr) imem[mem_addr[15:1]] <= mem_data_in;
  assign mem_rdata = imem[mem_addr[15:1]];

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] pc;
    logic        vld;
    logic        err;
    logic        ack;
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fetch_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  int          m_state = S_IDLE;
  logic [15:0] m_pc = 16'h0000;
  bit          m_known = 1'b0;
  logic [15:0] ref_mem [0:32767];

  task automatic model_step();
    exp_t        e;
    int          nst;
    logic [15:0] npc;
    e       = '0;
    e.st    = 3'(m_state);
    e.pc    = m_pc;
    e.err   = (m_state == S_ERR);
    nst     = m_state;
    npc     = m_pc;
    case (m_state)
      S_IDLE, S_HALT: begin
        if (ld_req) nst = S_LOAD;
        else if (start) nst = S_RUN;
      end
      S_LOAD: begin
        if (ld_req) begin
          e.en = 1'b1; e.wr = 1'b1; e.addr = ld_addr; e.din = ld_data; e.ack = 1'b1;
          ref_mem[ld_addr[15:1]] = ld_data;
        end
        if (mem_err) nst = S_ERR;
        else if (!ld_req) nst = S_IDLE;
      end
      S_RUN: begin
        e.en   = 1'b1;
        e.addr = m_pc;
        e.vld  = !(stall_p1 || redirect_valid || halt || mem_err);
        if (e.vld && m_known) fetch_q.push_back({m_pc, ref_mem[m_pc[15:1]]});
        if (mem_err) nst = S_ERR;
        else if (halt) nst = S_HALT;
        else if (redirect_valid) begin
          if (redirect_pc[0]) nst = S_ERR;
          else npc = redirect_pc;
        end else if (!stall_p1) begin
          npc = 16'((int'(m_pc) + 2) % 65536);
        end
      end
      default: ;
    endcase
    if (m_known) exp_q.push_back(e);
    if (rst) begin
      nst     = S_IDLE;
      npc     = 16'h0000;
      m_known = 1'b1;
    end
    m_state = nst;
    m_pc    = npc;
  endtask

  task automatic clr_in();
    rst = 1'b0; start = 1'b0; halt = 1'b0; stall_p1 = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0000; ld_req = 1'b0; ld_addr = 16'h0000; ld_data = 16'h0000;
    mem_err = 1'b0;
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  // Monitor
  exp_t        mon_e;
  exp_t        mon_g;
  logic [31:0] mon_f;
  bit          mon_live;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      mon_live = 1'b0;
      if (exp_q.size() > 0) begin
        mon_live = 1'b1;
        mon_e = exp_q.pop_front();
        mon_g = {state_p1, pc_p1, inst_valid_p1, err_p1, ld_ack, mem_enable, mem_wr,
                 mem_addr, mem_data_in};
        checks++;
        if (mon_g !== mon_e) begin
          errors++;
          $display("FAIL cycle_rec t=%0t got st=%0d pc=%h vld=%b err=%b ack=%b en=%b wr=%b addr=%h din=%h exp st=%0d pc=%h vld=%b err=%b ack=%b en=%b wr=%b addr=%h din=%h",
                   $time, mon_g.st, mon_g.pc, mon_g.vld, mon_g.err, mon_g.ack, mon_g.en,
                   mon_g.wr, mon_g.addr, mon_g.din, mon_e.st, mon_e.pc, mon_e.vld, mon_e.err,
                   mon_e.ack, mon_e.en, mon_e.wr, mon_e.addr, mon_e.din);
        end
      end
      if (mon_live && inst_valid_p1 === 1'b1) begin
        checks++;
        if (fetch_q.size() == 0) begin
          errors++;
          $display("FAIL fetch_unexpected t=%0t got pc=%h data=%h exp none", $time, pc_p1, mem_rdata);
        end else begin
          mon_f = fetch_q.pop_front();
          if ({pc_p1, mem_rdata} !== mon_f) begin
            errors++;
            $display("FAIL fetch_data t=%0t got pc=%h data=%h exp pc=%h data=%h",
                     $time, pc_p1, mem_rdata, mon_f[31:16], mon_f[15:0]);
          end
        end
      end
    end
  end

  // Driver
  initial begin
    for (int i = 0; i < 32768; i++) begin
      imem[i]    = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    clr_in();
    @(negedge clk);

    // reset, then plain fetch 0,2,4,6
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();

    // halt at 0x0008, then ld_req+start together -> LOAD, then resume at 0x0008
    halt = 1'b1; cyc(); halt = 1'b0;
    ld_req = 1'b1; start = 1'b1; ld_addr = 16'h0040; ld_data = 16'h1234; cyc();
    start = 1'b0; cyc();
    ld_addr = 16'h0042; ld_data = 16'h5678; cyc();
    ld_req = 1'b0; cyc();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (2) cyc();

    // loader writes three words, then fetches return them
    rst = 1'b1; cyc(); rst = 1'b0;
    ld_req = 1'b1; ld_addr = 16'h0000; ld_data = 16'hA001; cyc(); cyc();
    ld_addr = 16'h0002; ld_data = 16'hA002; cyc();
    ld_addr = 16'h0004; ld_data = 16'hA003; cyc();
    clr_in(); cyc();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();

    // stall at 0x0010, then stall+redirect to 0x0100
    for (int i = 0; i < 16 && m_pc != 16'h0010; i++) cyc();
    stall_p1 = 1'b1; cyc(); cyc();
    redirect_valid = 1'b1; redirect_pc = 16'h0100; cyc();
    stall_p1 = 1'b0; redirect_valid = 1'b0; cyc(); cyc();

    // wrap at 0xFFFE
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE; cyc();
    redirect_valid = 1'b0; repeat (3) cyc();

    // odd target -> sticky ERR, only rst clears
    redirect_valid = 1'b1; redirect_pc = 16'h0101; cyc();
    redirect_valid = 1'b0; start = 1'b1; ld_req = 1'b1; repeat (3) cyc();
    clr_in(); rst = 1'b1; cyc(); rst = 1'b0; cyc();

    // mem_err in RUN
    start = 1'b1; cyc(); start = 1'b0; cyc();
    mem_err = 1'b1; cyc(); mem_err = 1'b0; cyc();
    rst = 1'b1; cyc(); rst = 1'b0;

    // mem_err in LOAD: write still acked that cycle
    ld_req = 1'b1; ld_addr = 16'h0008; ld_data = 16'hBEEF; cyc();
    mem_err = 1'b1; cyc(); mem_err = 1'b0; cyc();
    ld_req = 1'b0; rst = 1'b1; cyc(); rst = 1'b0;

    // reset in the middle of a loader write
    ld_req = 1'b1; ld_addr = 16'h000A; ld_data = 16'h5555; cyc();
    rst = 1'b1; cyc(); rst = 1'b0; ld_req = 1'b0; cyc(); cyc();

    // randomized phase
    for (int n = 0; n < 800; n++) begin
      rst            = ($urandom_range(0, 99) == 0) || (m_state == S_ERR && $urandom_range(0, 7) == 0);
      start          = ($urandom_range(0, 3) == 0);
      halt           = ($urandom_range(0, 15) == 0);
      stall_p1       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 5) == 0);
      redirect_pc    = 16'($urandom()) & 16'h01FE;
      if ($urandom_range(0, 19) == 0) redirect_pc[0] = 1'b1;
      ld_req         = ($urandom_range(0, 2) == 0);
      ld_addr        = 16'($urandom()) & 16'h00FE;
      ld_data        = 16'($urandom());
      mem_err        = ($urandom_range(0, 59) == 0);
      cyc();
    end
    clr_in();
    cyc();
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drain got %0d left exp 0", exp_q.size());
    end
    checks++;
    if (fetch_q.size() != 0) begin
      errors++;
      $display("FAIL fetch_q_drain got %0d left exp 0", fetch_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
